store_uart_tx: RTL and testbench
================================

Name: store_uart_tx

Overview:
- Memory-mapped store-to-serial peripheral on the processor's data-side bus, downstream of the single-cycle core top.
- Consumes the same MemWrite/DataAdr/WriteData signals that drive dmem; dmem is unaffected.
- Stores to one decoded address are queued in a byte FIFO and transmitted on an 8N1 UART line.
- Gives programs a console/trace output on the board.

Parameters:
- MMIO_ADDR, 32'hFFFF_FF00, byte address decoded as the TX data register (exact 32-bit compare).
- CLKS_PER_BIT, 4, clk cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 8, byte FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- MemWrite  input  1  store strobe from core
- DataAdr  input  32  store address (ALU result)
- WriteData  input  32  store data; bits [7:0] are transmitted
- tx  output  1  UART serial out, idle high
- busy  output  1  high while FIFO non-empty or a frame is in progress
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries
- drop_count  output  8  count of stores discarded because the FIFO was full

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset, sampled on a rising edge:
  - tx=1, busy=0, fifo_full=0, drop_count=0.
  - FIFO emptied, FSM to IDLE, bit and tick counters cleared.
- Reset asserted mid-frame aborts the frame; tx is high after that edge.
- Push condition: MemWrite && DataAdr==MMIO_ADDR at a rising edge.
  - FIFO not full: WriteData[7:0] is written at that edge.
  - FIFO full (count==FIFO_DEPTH before the edge): the byte is discarded, even if a pop happens on the same edge. drop_count increments and saturates at 255.
- Other addresses and MemWrite=0 are ignored.
- Push and pop on the same edge with FIFO not full: both take effect and the count is unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap. Count is log2(FIFO_DEPTH)+1 bits.
- fifo_full and busy are registered and reflect post-edge state.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop head into the shift register, go to START, tx<=0.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: drive shift[0] (LSB first) for CLKS_PER_BIT cycles per bit, 8 bits, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if FIFO non-empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- Latency: a store accepted at edge E0 into an empty, idle block drives tx low from edge E0+1.
- Frame length is 10*CLKS_PER_BIT cycles.
- tx is a registered output; no combinational path from inputs to tx.
- busy = (FSM != IDLE) || FIFO non-empty.

Optional Feature:
- Macro: STORE_UART_PARITY_EN.
- Defined: a PARITY state follows DATA and drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles before STOP. Frame is 8E1, 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, 8N1, 10*CLKS_PER_BIT cycles.
- All other behaviour is identical in both builds.

Test Plan:
- Single byte: CLKS_PER_BIT=4, store 32'h0000_00A5 to 32'hFFFF_FF00 at E0.
  - tx=0 over E0+1..E0+4.
  - Then 4 cycles each of bits 1,0,1,0,0,1,0,1.
  - Stop high 4 cycles.
  - busy falls at E0+41.
- Address decode and byte select:
  - Stores to 32'hFFFF_FF04 and to 32'h0000_0040 -> tx stays 1, busy stays 0.
  - Store 32'h1234_5678 to MMIO_ADDR -> frame carries 8'h78.
- Overflow: 10 stores on consecutive edges E0..E9, bytes 0x01..0x0A.
  - 0x01 popped at E1; fifo_full=1 after E8.
  - 0x0A dropped, drop_count=1.
  - Nine frames 0x01..0x09 transmitted back-to-back with no idle cycle between stop and start.
- Saturation: 300 stores while full -> drop_count=255 and holds there.
- Reset mid-frame: assert reset during DATA bit 3.
  - After that edge: tx=1, busy=0, fifo_full=0, drop_count=0.
  - A following store transmits normally.
- STORE_UART_PARITY_EN build: store 8'h07 -> parity bit 1; store 8'h03 -> parity bit 0; frame 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/store_uart_tx.sv
// store_uart_tx: memory-mapped store-to-UART transmitter.
// Stores to MMIO_ADDR are queued in a small byte FIFO. Each byte is sent
// LSB first on tx as an 8N1 frame, and frames run back-to-back while data
// is waiting. Stores that arrive while the FIFO is full are dropped and
// counted in drop_count, which saturates at 255.
// Optional build macro: STORE_UART_PARITY_EN adds an even-parity bit (8E1).
module store_uart_tx #(
    parameter logic [31:0] MMIO_ADDR    = 32'hFFFF_FF00,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic [7:0]  drop_count
);
    localparam int              PW         = $clog2(FIFO_DEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [15:0]     TICK_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   COUNT_FULL = CW'(FIFO_DEPTH);

`ifdef STORE_UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          r_state;
    state_t          w_state_next;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;

    logic [7:0]      r_shift;
    logic [15:0]     r_tick;
    logic [2:0]      r_bit;
    logic            r_tx;
    logic            r_busy;
    logic            r_fifo_full;
    logic [7:0]      r_drop_count;
`ifdef STORE_UART_PARITY_EN
    logic            r_parity;
`endif

    logic            w_push_req;
    logic            w_fifo_empty;
    logic            w_fifo_is_full;
    logic            w_push;
    logic            w_drop;
    logic            w_pop;
    logic            w_tick_done;
    logic            w_tx_next;

    // The full test uses the count from before the edge, so a store that
    // meets a full FIFO is dropped even if a pop happens on the same edge.
    assign w_push_req     = MemWrite && (DataAdr == MMIO_ADDR);
    assign w_fifo_empty   = (r_count == '0);
    assign w_fifo_is_full = (r_count == COUNT_FULL);
    assign w_push         = w_push_req && !w_fifo_is_full;
    assign w_drop         = w_push_req && w_fifo_is_full;
    assign w_tick_done    = (r_tick == TICK_LAST);

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_full  = r_fifo_full;
    assign drop_count = r_drop_count;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // FSM next-state logic: one bit period per state step, 8 data bits
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (!w_fifo_empty) w_state_next = S_START;
            S_START:  if (w_tick_done)   w_state_next = S_DATA;
`ifdef STORE_UART_PARITY_EN
            S_DATA:   if (w_tick_done && r_bit == 3'd7) w_state_next = S_PARITY;
            S_PARITY: if (w_tick_done)   w_state_next = S_STOP;
`else
            S_DATA:   if (w_tick_done && r_bit == 3'd7) w_state_next = S_STOP;
`endif
            S_STOP:   if (w_tick_done)   w_state_next = w_fifo_empty ? S_IDLE : S_START;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: pop strobe and the line level for the next cycle
    always_comb begin
        w_pop     = !w_fifo_empty &&
                    ((r_state == S_IDLE) || (r_state == S_STOP && w_tick_done));
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            // Entering DATA the shifter already holds bit 0; at each later
            // bit boundary the next bit is the one about to shift down.
            S_DATA:   w_tx_next = (r_state == S_DATA && w_tick_done) ? r_shift[1] : r_shift[0];
`ifdef STORE_UART_PARITY_EN
            S_PARITY: w_tx_next = r_parity;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    // FIFO occupancy after simultaneous push/pop
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)      w_count_next = r_count + CW'(1);
        else if (!w_push && w_pop) w_count_next = r_count - CW'(1);
    end

    // FIFO storage: plain array written on accepted stores
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= WriteData[7:0];
    end

    // Datapath: pointers, shifter, bit timing and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_shift      <= '0;
            r_tick       <= '0;
            r_bit        <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_fifo_full  <= 1'b0;
            r_drop_count <= '0;
`ifdef STORE_UART_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_shift  <= r_mem[r_rd_ptr];
`ifdef STORE_UART_PARITY_EN
                r_parity <= ^r_mem[r_rd_ptr];
`endif
            end else if (r_state == S_DATA && w_tick_done) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
            r_count <= w_count_next;

            // Tick counter restarts at every bit boundary and idles at zero
            r_tick <= (r_state == S_IDLE || w_tick_done) ? '0 : r_tick + 16'd1;

            if (r_state == S_START)                    r_bit <= '0;
            else if (r_state == S_DATA && w_tick_done) r_bit <= r_bit + 3'd1;

            r_tx        <= w_tx_next;
            r_busy      <= (w_state_next != S_IDLE) || (w_count_next != '0);
            r_fifo_full <= (w_count_next == COUNT_FULL);

            if (w_drop && r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_store_uart_tx.sv
// tb_store_uart_tx: randomized and directed bench for store_uart_tx.
// The reference model keeps a byte queue plus the current frame as a bit
// vector and a position within it; the expected line level is simply the
// frame bit at position/CLKS_PER_BIT. Build with STORE_UART_PARITY_EN
// defined to check the 8E1 variant.
module tb_store_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] MMIO  = 32'hFFFF_FF00;
`ifdef STORE_UART_PARITY_EN
    localparam int          FBITS = 11;
`else
    localparam int          FBITS = 10;
`endif
    localparam int          FLEN  = FBITS * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    store_uart_tx #(.MMIO_ADDR(MMIO), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .drop_count (drop_count)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    byte unsigned     m_q[$];
    bit               m_active = 1'b0;
    int               m_pos = 0;
    logic [FBITS-1:0] m_frame = '1;
    int               m_drops = 0;

    function automatic logic [FBITS-1:0] make_frame(input logic [7:0] b);
`ifdef STORE_UART_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    function automatic logic m_tx();
        return m_active ? m_frame[m_pos / CPB] : 1'b1;
    endfunction

    function automatic void model_edge(input bit rst, input bit req, input logic [7:0] d);
        bit was_full;
        bit had_data;
        if (rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_drops  = 0;
            return;
        end
        was_full = (m_q.size() == DEPTH);
        had_data = (m_q.size() != 0);
        if (m_active && m_pos != FLEN - 1) begin
            m_pos++;
        end else if (had_data) begin
            m_frame  = make_frame(m_q.pop_front());
            m_active = 1'b1;
            m_pos    = 0;
        end else begin
            m_active = 1'b0;
        end
        if (req) begin
            if (was_full) m_drops = (m_drops < 255) ? m_drops + 1 : 255;
            else          m_q.push_back(d);
        end
    endfunction

    // One clock: apply inputs, advance model on the edge, compare after it
    task automatic step(input bit mw, input logic [31:0] adr, input logic [31:0] wd);
        bit    req;
        string st;
        MemWrite  = mw;
        DataAdr   = adr;
        WriteData = wd;
        req = mw && (adr == MMIO);
        if (reset)                     st = "ignored (reset)";
        else if (!req)                 st = "ignored";
        else if (m_q.size() == DEPTH)  st = "dropped";
        else                           st = "accepted";
        @(posedge clk);
        model_edge(reset, req && !reset, wd[7:0]);
        if (mw) $display("store adr=%08h data=%08h -> %s", adr, wd, st);
        #1;
        MemWrite = 1'b0;
        check("tx", tx, m_tx());
        check("busy", busy, m_active || m_q.size() != 0);
        check("fifo_full", fifo_full, m_q.size() == DEPTH);
        check("drop_count", drop_count, m_drops);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, '0, '0);
        reset = 1'b0;
    endtask

    // Wait (bounded) for busy to drop; returns number of steps taken
    task automatic drain(input int limit, output int n);
        n = 0;
        while (busy && n < limit) begin
            step(1'b0, '0, '0);
            n++;
        end
        check("drain_timeout", busy, 1'b0);
    endtask

    // Send one byte into an idle block and decode the line independently
    task automatic send_capture(input logic [31:0] wd, output logic [7:0] data,
                                output logic par, output logic start_b,
                                output logic stop_b, output int len);
        logic samp [0:255];
        for (int i = 0; i < 256; i++) samp[i] = 1'b1;
        step(1'b1, MMIO, wd);
        len = 0;
        do begin
            step(1'b0, '0, '0);
            samp[len] = tx;
            len++;
        end while (busy && len < 200);
        start_b = samp[1];
        for (int i = 0; i < 8; i++) data[i] = samp[(1 + i) * CPB + 1];
        par    = samp[9 * CPB + 1];
        stop_b = samp[(FBITS - 1) * CPB + 1];
    endtask

    initial begin
        logic [7:0] got_b;
        logic       par_b, start_b, stop_b;
        int         len, n, e, guard;

        // Reset state
        do_reset();
        do_reset();
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_full", fifo_full, 1'b0);
        check("rst_drops", drop_count, 8'd0);

        // Single byte 0xA5: latency and frame length
        step(1'b1, MMIO, 32'h0000_00A5);
        step(1'b0, '0, '0);
        check("latency_tx_low", tx, 1'b0);
        e = 1;
        while (busy && e < 100) begin
            step(1'b0, '0, '0);
            e++;
        end
        check("busy_fall_cycle", e, FLEN + 1);

        // Address decode: neighbouring and unrelated addresses ignored
        step(1'b1, 32'hFFFF_FF04, 32'h0000_0055);
        step(1'b1, 32'h0000_0040, 32'h0000_0055);
        idle(3);
        check("decode_tx_idle", tx, 1'b1);
        check("decode_busy", busy, 1'b0);

        // Byte select: only WriteData[7:0] goes on the line
        send_capture(32'h1234_5678, got_b, par_b, start_b, stop_b, len);
        check("bytesel_data", got_b, 8'h78);
        check("bytesel_start", start_b, 1'b0);
        check("bytesel_stop", stop_b, 1'b1);
        check("bytesel_len", len, FLEN + 1);

        // Overflow: ten back-to-back stores, tenth is dropped
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, MMIO, 32'(i));
            if (i == 9) check("ovf_full_after_E8", fifo_full, 1'b1);
        end
        check("ovf_drop_count", drop_count, 8'd1);
        drain(1000, n);
        check("ovf_back_to_back_len", n + 9, 9 * FLEN + 1);

        // Saturation: fill, then 300 stores while full
        for (int i = 0; i < 9; i++) step(1'b1, MMIO, $urandom);
        for (int i = 0; i < 300; i++) step(1'b1, MMIO, $urandom);
        check("sat_drops", drop_count, 8'd255);
        step(1'b1, MMIO, 32'h0000_0011);
        check("sat_hold", drop_count, 8'd255);

        // Reset during data bit 3 of the frame in flight (FIFO still full)
        guard = 0;
        while (!(m_active && m_pos == 4 * CPB + 1) && guard < 200) begin
            step(1'b0, '0, '0);
            guard++;
        end
        check("midframe_reach", guard < 200, 1'b1);
        do_reset();
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_full", fifo_full, 1'b0);
        check("midrst_drops", drop_count, 8'd0);
        send_capture(32'h0000_00C3, got_b, par_b, start_b, stop_b, len);
        check("after_rst_data", got_b, 8'hC3);
        check("after_rst_len", len, FLEN + 1);

`ifdef STORE_UART_PARITY_EN
        send_capture(32'h0000_0007, got_b, par_b, start_b, stop_b, len);
        check("par07_data", got_b, 8'h07);
        check("par07_bit", par_b, 1'b1);
        check("par07_len", len, 45);
        send_capture(32'h0000_0003, got_b, par_b, start_b, stop_b, len);
        check("par03_data", got_b, 8'h03);
        check("par03_bit", par_b, 1'b0);
        check("par03_stop", stop_b, 1'b1);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 3) begin
                do_reset();
            end else if (r < 120) begin
                step(1'b1, MMIO, $urandom);
            end else if (r < 160) begin
                step(1'b1, MMIO ^ (32'h1 << $urandom_range(0, 31)), $urandom);
            end else if (r < 170) begin
                for (int k = 0; k < 12; k++) step(1'b1, MMIO, $urandom);
            end else begin
                step(1'b0, MMIO, $urandom);
            end
        end
        drain(2000, n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
